// File: rtl/step_decoder_seq.sv
// step_decoder_seq: control-step sequencer with one-hot and binary step outputs.
// A started sequence walks step_idx from 0 up to the latched last step, then
// pulses done. Hold stalls the walk and clr aborts back to idle.
// Optional build macro STEP_DECODER_SEQ_B2B_EN: a start seen during the final
// step launches the next sequence with no idle bubble.
module step_decoder_seq #(
  parameter int unsigned SEL_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      start,
  input  logic [SEL_W-1:0]          last_step,
  input  logic                      hold,
  input  logic                      clr,
  output logic [(1 << SEL_W)-1:0]   step,
  output logic [SEL_W-1:0]          step_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  localparam logic [OUT_W-1:0] StepFirst = OUT_W'(1);
  localparam logic [SEL_W-1:0] IdxOne    = SEL_W'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             r_state, w_state_d;
  logic [OUT_W-1:0]   r_step, w_step_d;
  logic [SEL_W-1:0]   r_step_idx, w_step_idx_d;
  logic [SEL_W-1:0]   r_last, w_last_d;
  logic               r_done, w_done_d;
  logic               w_final;

  assign w_final = (r_step_idx == r_last);

  // Next-state logic; priority is clr, then hold, then advance/finish, then start.
  always_comb begin
    w_state_d    = r_state;
    w_step_d     = r_step;
    w_step_idx_d = r_step_idx;
    w_last_d     = r_last;
    w_done_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!clr && start) begin
          w_state_d    = StRun;
          w_step_d     = StepFirst;
          w_step_idx_d = '0;
          w_last_d     = last_step;
        end
      end
      StRun: begin
        if (clr) begin
          // Aborted sequences never report done.
          w_state_d    = StIdle;
          w_step_d     = '0;
          w_step_idx_d = '0;
        end else if (hold) begin
          w_state_d = StRun;
        end else if (!w_final) begin
          w_step_d     = r_step << 1;
          w_step_idx_d = r_step_idx + IdxOne;
        end else begin
          w_done_d = 1'b1;
`ifdef STEP_DECODER_SEQ_B2B_EN
          if (start) begin
            w_state_d    = StRun;
            w_step_d     = StepFirst;
            w_step_idx_d = '0;
            w_last_d     = last_step;
          end else begin
            w_state_d    = StIdle;
            w_step_d     = '0;
            w_step_idx_d = '0;
          end
`else
          w_state_d    = StIdle;
          w_step_d     = '0;
          w_step_idx_d = '0;
`endif
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_step_d     = '0;
        w_step_idx_d = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= StIdle;
      r_step     <= '0;
      r_step_idx <= '0;
      r_last     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_step     <= w_step_d;
      r_step_idx <= w_step_idx_d;
      r_last     <= w_last_d;
      r_done     <= w_done_d;
    end
  end

  assign step     = r_step;
  assign step_idx = r_step_idx;
  assign busy     = (r_state == StRun);
  assign done     = r_done;

endmodule

// File: tb/tb_step_decoder_seq.sv
// tb_step_decoder_seq: scoreboard bench for step_decoder_seq (SEL_W = 3).
// Expected outputs come from a behavioural model evaluated when inputs are
// driven, queued, and compared after the following rising edge.
module tb_step_decoder_seq;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;

  logic             clk;
  logic             rst_b;
  logic             start;
  logic [SEL_W-1:0] last_step;
  logic             hold;
  logic             clr;
  logic [OUT_W-1:0] step;
  logic [SEL_W-1:0] step_idx;
  logic             busy;
  logic             done;

  step_decoder_seq #(.SEL_W(SEL_W)) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .last_step (last_step),
    .hold      (hold),
    .clr       (clr),
    .step      (step),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] idx;
    logic [OUT_W-1:0] step;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic m_busy;
  logic m_done;
  int   m_idx;
  int   m_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] onehot(input int idx);
    logic [OUT_W-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic s, input int ls, input logic h, input logic c);
    if (!m_busy) begin
      m_done = 1'b0;
      if (!c && s) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_last = ls;
      end
    end else if (c) begin
      m_busy = 1'b0;
      m_idx  = 0;
      m_done = 1'b0;
    end else if (h) begin
      m_done = 1'b0;
    end else if (m_idx < m_last) begin
      m_idx++;
      m_done = 1'b0;
    end else begin
      m_done = 1'b1;
`ifdef STEP_DECODER_SEQ_B2B_EN
      if (s) begin
        m_idx  = 0;
        m_last = ls;
      end else begin
        m_busy = 1'b0;
        m_idx  = 0;
      end
`else
      m_busy = 1'b0;
      m_idx  = 0;
`endif
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, "_busy"}, 32'(busy), 32'(e.busy));
    check_val({tag, "_done"}, 32'(done), 32'(e.done));
    check_val({tag, "_idx"},  32'(step_idx), 32'(e.idx));
    check_val({tag, "_step"}, 32'(step), 32'(e.step));
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cycle(input string tag, input logic s, input int ls, input logic h,
                       input logic c);
    exp_t e;
    @(negedge clk);
    start     = s;
    last_step = SEL_W'(ls);
    hold      = h;
    clr       = c;
    model_step(s, ls, h, c);
    e.busy = m_busy;
    e.done = m_done;
    e.idx  = SEL_W'(m_idx);
    e.step = m_busy ? onehot(m_idx) : '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
    m_last = 0;
  endtask

  initial begin
    start     = 1'b0;
    last_step = '0;
    hold      = 1'b0;
    clr       = 1'b0;
    rst_b     = 1'b0;
    model_reset();
    #12;
    check_val("rst_step", 32'(step), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_idx",  32'(step_idx), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // T2: five-step sequence then done.
    cycle("t2_start", 1'b1, 4, 1'b0, 1'b0);
    idle_cycles("t2_run", 7);

    // T3: hold at step_idx 1 for three cycles.
    cycle("t3_start", 1'b1, 2, 1'b0, 1'b0);
    cycle("t3_adv", 1'b0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t3_hold", 1'b0, 2, 1'b1, 1'b0);
    idle_cycles("t3_tail", 4);
    // Hold in idle is ignored.
    for (int i = 0; i < 2; i++) cycle("idle_hold", 1'b0, 3, 1'b1, 1'b0);

    // T4: clr with hold and start at step_idx 2.
    cycle("t4_start", 1'b1, 5, 1'b0, 1'b0);
    idle_cycles("t4_adv", 2);
    cycle("t4_clr", 1'b1, 6, 1'b1, 1'b1);
    idle_cycles("t4_after", 3);
    // clr together with start in idle stays idle.
    cycle("clr_start_idle", 1'b1, 3, 1'b0, 1'b1);
    idle_cycles("clr_idle_after", 1);

    // T5: single-step and full-sweep sequences.
    cycle("t5_single", 1'b1, 0, 1'b0, 1'b0);
    idle_cycles("t5_single_tail", 3);
    cycle("t5_full", 1'b1, 7, 1'b0, 1'b0);
    idle_cycles("t5_full_run", 10);

    // last_step and start changes while busy must be ignored.
    cycle("ign_start", 1'b1, 3, 1'b0, 1'b0);
    cycle("ign_ls0", 1'b1, 0, 1'b0, 1'b0);
    cycle("ign_ls7", 1'b0, 7, 1'b0, 1'b0);
    idle_cycles("ign_tail", 4);

    // T6: start held high through the final step.
    for (int i = 0; i < 10; i++) cycle("t6_b2b", 1'b1, 2, 1'b0, 1'b0);
    idle_cycles("t6_tail", 5);

    // Random mix of all inputs.
    for (int i = 0; i < 300; i++) begin
      cycle("rand",
            1'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 15) == 0));
    end
    idle_cycles("rand_tail", 9);

    // T1: asynchronous reset mid-sequence at step_idx 3, checked without a clock edge.
    cycle("t1_start", 1'b1, 6, 1'b0, 1'b0);
    idle_cycles("t1_adv", 3);
    check_val("t1_pre_idx", 32'(step_idx), 32'd3);
    #2;
    rst_b = 1'b0;
    #1;
    check_val("t1_step", 32'(step), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd0);
    check_val("t1_done", 32'(done), 32'd0);
    check_val("t1_idx",  32'(step_idx), 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_b = 1'b1;
    idle_cycles("t1_after", 2);
    cycle("t1_restart", 1'b1, 1, 1'b0, 1'b0);
    idle_cycles("t1_restart_run", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
